// File: rtl/prize_spawner.sv
// prize_spawner: turns a 10-bit random stream into on-screen prize
// placements, with rejection sampling, a lifetime timer and a cooldown.
module prize_spawner #(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int PRIZE_W         = 32,
    parameter int PRIZE_H         = 32,
    parameter int LIFETIME_FRAMES = 300,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int MAX_RETRY       = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        rand_valid,
    input  logic [9:0]  rand_value,
    input  logic        collected,
    output logic        rand_req,
    output logic        prize_active,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        prize_taken,
    output logic [7:0]  spawn_count
);
    localparam logic [10:0] MAX_X = 11'(SCREEN_W - PRIZE_W);
    localparam logic [10:0] MAX_Y = 11'(SCREEN_H - PRIZE_H);
    localparam int FMAX = (LIFETIME_FRAMES > COOLDOWN_FRAMES) ?
                          LIFETIME_FRAMES : COOLDOWN_FRAMES;
    localparam int FW = $clog2(FMAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [FW-1:0] LIFE_LAST  = FW'(LIFETIME_FRAMES - 1);
    localparam logic [FW-1:0] COOL_LAST  = FW'(COOLDOWN_FRAMES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_X,
        REQ_Y,
        ACTIVE,
        COOLDOWN
    } state_t;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [RW-1:0] retry;
    logic [10:0]   x_hold;
    logic [10:0]   val_ext;
    logic          grant;
    logic          last_try;

    assign val_ext  = {1'b0, rand_value};
    assign grant    = rand_req && rand_valid;
    assign last_try = (retry == RETRY_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            retry        <= '0;
            x_hold       <= '0;
            rand_req     <= 1'b0;
            prize_active <= 1'b0;
            topLeftX     <= '0;
            topLeftY     <= '0;
            prize_taken  <= 1'b0;
            spawn_count  <= '0;
        end else begin
            prize_taken <= 1'b0;
            if (!enable) begin
                state        <= IDLE;
                rand_req     <= 1'b0;
                prize_active <= 1'b0;
                retry        <= '0;
                frame_cnt    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= REQ_X;
                        retry <= '0;
                    end
                    REQ_X: begin
                        if (grant) begin
                            rand_req <= 1'b0;
                            if (val_ext <= MAX_X) begin
                                x_hold <= val_ext;
                                retry  <= '0;
                                state  <= REQ_Y;
                            end else if (last_try) begin
                                x_hold <= {2'b00, rand_value[9:1]};
                                retry  <= '0;
                                state  <= REQ_Y;
                            end else begin
                                retry <= retry + RW'(1);
                            end
                        end else begin
                            rand_req <= 1'b1;
                        end
                    end
                    REQ_Y: begin
                        if (grant) begin
                            rand_req <= 1'b0;
                            if (val_ext <= MAX_Y || last_try) begin
                                topLeftY <= (val_ext <= MAX_Y) ? val_ext :
                                            {3'b000, rand_value[9:2]};
                                topLeftX     <= x_hold;
                                prize_active <= 1'b1;
                                spawn_count  <= spawn_count + 8'd1;
                                frame_cnt    <= '0;
                                retry        <= '0;
                                state        <= ACTIVE;
                            end else begin
                                retry <= retry + RW'(1);
                            end
                        end else begin
                            rand_req <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        // collection outranks expiry on the final frame
                        if (collected) begin
                            prize_taken  <= 1'b1;
                            prize_active <= 1'b0;
                            frame_cnt    <= '0;
                            state        <= COOLDOWN;
                        end else if (startOfFrame) begin
                            if (frame_cnt == LIFE_LAST) begin
                                prize_active <= 1'b0;
                                frame_cnt    <= '0;
                                state        <= COOLDOWN;
                            end else begin
                                frame_cnt <= frame_cnt + FW'(1);
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (startOfFrame) begin
                            if (frame_cnt == COOL_LAST) begin
                                frame_cnt <= '0;
                                retry     <= '0;
                                state     <= REQ_X;
                            end else begin
                                frame_cnt <= frame_cnt + FW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prize_spawner.sv
// tb_prize_spawner: table of spawn vectors with a placement scoreboard,
// plus hand-written lifetime, cooldown, handshake and reset sequences.
module tb_prize_spawner;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        enable = 1'b0;
    logic        rand_valid = 1'b0;
    logic [9:0]  rand_value = '0;
    logic        collected = 1'b0;
    logic        rand_req;
    logic        prize_active;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        prize_taken;
    logic [7:0]  spawn_count;

    int checks = 0;
    int errors = 0;
    int taken_cnt = 0;
    int exp_cnt = 0;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct packed {
        logic [2:0]       nx;
        logic [3:0][9:0]  xs;
        logic [2:0]       ny;
        logic [3:0][9:0]  ys;
        logic [10:0]      ex;
        logic [10:0]      ey;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    prize_spawner dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .enable(enable),
        .rand_valid(rand_valid),
        .rand_value(rand_value),
        .collected(collected),
        .rand_req(rand_req),
        .prize_active(prize_active),
        .topLeftX(topLeftX),
        .topLeftY(topLeftY),
        .prize_taken(prize_taken),
        .spawn_count(spawn_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (prize_taken === 1'b1) taken_cnt <= taken_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [3:0][9:0] v4(input logic [9:0] a, input logic [9:0] b,
                                           input logic [9:0] c, input logic [9:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic serve(input logic [9:0] v);
        int n;
        n = 0;
        while (rand_req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("req_wait", 32'(n < 200), 1);
        rand_valid = 1'b1;
        rand_value = v;
        tick();
        rand_valid = 1'b0;
        chk("req_drop", 32'(rand_req), 0);
    endtask

    task automatic spawn(input logic [3:0][9:0] xs, input int nx,
                         input logic [3:0][9:0] ys, input int ny,
                         input logic [10:0] ex, input logic [10:0] ey);
        exp_t e;
        int n;
        exp_cnt = (exp_cnt + 1) % 256;
        sb.push_back('{x: ex, y: ey, cnt: 8'(exp_cnt)});
        for (int i = 0; i < nx; i++) serve(xs[i]);
        for (int i = 0; i < ny; i++) begin
            chk("early_active", 32'(prize_active), 0);
            serve(ys[i]);
        end
        n = 0;
        while (prize_active !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        chk("spawn_active", 32'(prize_active), 1);
        chk("topLeftX", 32'(topLeftX), 32'(e.x));
        chk("topLeftY", 32'(topLeftY), 32'(e.y));
        chk("spawn_count", 32'(spawn_count), 32'(e.cnt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 32'(rand_req), 0);
        chk({tag, "_active"}, 32'(prize_active), 0);
        chk({tag, "_taken"}, 32'(prize_taken), 0);
        chk({tag, "_count"}, 32'(spawn_count), 0);
    endtask

    initial begin
        int base;
        int highs;
        int viol;
        int n;
        logic prev;
        exp_t e;

        tbl[0] = '{3'd1, v4(100, 0, 0, 0), 3'd1, v4(200, 0, 0, 0), 11'd100, 11'd200};
        tbl[1] = '{3'd3, v4(700, 650, 608, 0), 3'd4, v4(449, 449, 449, 449), 11'd608, 11'd112};
        tbl[2] = '{3'd4, v4(1023, 609, 700, 1000), 3'd1, v4(448, 0, 0, 0), 11'd500, 11'd448};
        tbl[3] = '{3'd1, v4(0, 0, 0, 0), 3'd1, v4(0, 0, 0, 0), 11'd0, 11'd0};
        tbl[4] = '{3'd4, v4(900, 900, 900, 513), 3'd4, v4(1023, 1023, 1023, 1023), 11'd513, 11'd255};
        tbl[5] = '{3'd4, v4(609, 609, 609, 609), 3'd4, v4(479, 460, 449, 450), 11'd304, 11'd112};

        repeat (3) tick();
        chk_zero("reset");
        chk("reset_x", 32'(topLeftX), 0);
        chk("reset_y", 32'(topLeftY), 0);
        resetN = 1'b1;
        tick();
        tick();
        chk("idle_no_req", 32'(rand_req), 0);
        enable = 1'b1;
        tick();
        chk("req_latency", 32'(rand_req), 0);
        tick();
        chk("req_rise", 32'(rand_req), 1);

        base = taken_cnt;
        for (int i = 0; i < 6; i++) begin
            spawn(tbl[i].xs, int'(tbl[i].nx), tbl[i].ys, int'(tbl[i].ny), tbl[i].ex, tbl[i].ey);
            collected = 1'b1;
            tick();
            collected = 1'b0;
            chk("tbl_taken", 32'(prize_taken), 1);
            chk("tbl_inactive", 32'(prize_active), 0);
            tick();
            chk("tbl_taken_pulse", 32'(prize_taken), 0);
            chk("tbl_taken_cnt", 32'(taken_cnt), 32'(base + i + 1));
            frames(60);
        end

        // lifetime expiry without collection, then cooldown length
        spawn(v4(400, 0, 0, 0), 1, v4(250, 0, 0, 0), 1, 11'd400, 11'd250);
        base = taken_cnt;
        frames(299);
        chk("life_299", 32'(prize_active), 1);
        frames(1);
        chk("life_300", 32'(prize_active), 0);
        chk("life_hold_x", 32'(topLeftX), 400);
        frames(59);
        chk("cool_59", 32'(rand_req), 0);
        frames(1);
        chk("cool_60", 32'(rand_req), 1);
        chk("life_no_taken", 32'(taken_cnt), 32'(base));

        // collection on the final frame wins
        spawn(v4(50, 0, 0, 0), 1, v4(60, 0, 0, 0), 1, 11'd50, 11'd60);
        frames(299);
        startOfFrame = 1'b1;
        collected = 1'b1;
        tick();
        startOfFrame = 1'b0;
        collected = 1'b0;
        chk("race_taken", 32'(prize_taken), 1);
        chk("race_inactive", 32'(prize_active), 0);
        tick();
        chk("race_pulse_end", 32'(prize_taken), 0);
        chk("race_taken_cnt", 32'(taken_cnt), 32'(base + 1));
        collected = 1'b1;
        tick();
        collected = 1'b0;
        chk("cool_collect_ign", 32'(prize_taken), 0);
        tick();
        frames(59);
        chk("race_cool_59", 32'(rand_req), 0);
        frames(1);
        chk("race_cool_60", 32'(rand_req), 1);
        chk("cool_taken_cnt", 32'(taken_cnt), 32'(base + 1));

        // rand_valid held high: one sample per request, gaps between
        exp_cnt = (exp_cnt + 1) % 256;
        sb.push_back('{x: 11'd300, y: 11'd300, cnt: 8'(exp_cnt)});
        rand_value = 10'd300;
        rand_valid = 1'b1;
        highs = 0;
        viol = 0;
        prev = 1'b0;
        n = 0;
        while (prize_active !== 1'b1 && n < 20) begin
            if (rand_req === 1'b1) begin
                highs++;
                if (prev) viol++;
            end
            prev = rand_req;
            tick();
            n++;
        end
        rand_valid = 1'b0;
        chk("cont_req_count", 32'(highs), 2);
        chk("cont_req_gap", 32'(viol), 0);
        e = sb.pop_front();
        chk("cont_x", 32'(topLeftX), 32'(e.x));
        chk("cont_y", 32'(topLeftY), 32'(e.y));
        chk("cont_count", 32'(spawn_count), 32'(e.cnt));
        collected = 1'b1;
        tick();
        collected = 1'b0;
        frames(60);

        // async reset while requesting Y
        serve(10'd10);
        n = 0;
        while (rand_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("reqy_high", 32'(rand_req), 1);
        #2;
        resetN = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        resetN = 1'b1;
        tick();
        exp_cnt = 0;
        spawn(v4(20, 0, 0, 0), 1, v4(30, 0, 0, 0), 1, 11'd20, 11'd30);

        // enable dropped while active
        base = taken_cnt;
        enable = 1'b0;
        tick();
        chk("dis_active", 32'(prize_active), 0);
        chk("dis_req", 32'(rand_req), 0);
        collected = 1'b1;
        tick();
        collected = 1'b0;
        chk("dis_taken", 32'(prize_taken), 0);
        tick();
        enable = 1'b1;
        tick();
        chk("reen_latency", 32'(rand_req), 0);
        tick();
        chk("reen_req", 32'(rand_req), 1);
        spawn(v4(608, 0, 0, 0), 1, v4(448, 0, 0, 0), 1, 11'd608, 11'd448);
        chk("dis_taken_cnt", 32'(taken_cnt), 32'(base));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
